muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit with HI/LO registers, sitting in the EX stage beside the ALU.
- Receives the same A/B operands from the ID/EX register.
- Returns a busy/done handshake to the hazard unit, which stalls IF/ID/EX while busy.
- Serves MULT, MULTU, DIV, DIVU, MTHI and MTLO; MFHI/MFLO read the hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  issue request, sampled on clk edge
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- A  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- B  input  WIDTH  rt operand (multiplier / divisor)
- cancel  input  1  flush; aborts an in-flight operation
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse after hi/lo update from MULT/DIV
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Applies even mid-operation; partial results are discarded.
- States: IDLE -> CALC (exactly 32 cycles) -> FIX (1 cycle) -> IDLE.
- Issue (IDLE, start=1, op in 000..011) at edge E0:
  - latch |A|, |B| (signed ops) or A, B (unsigned ops);
  - latch result signs; counter=0; enter CALC.
  - busy is high in the cycles after E0 through E33.
- CALC:
  - multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
  - divide: restoring, one quotient bit per cycle.
  - counter increments each edge; leave CALC at E32 when counter=31.
- FIX:
  - signed ops: negate the 64-bit product if signs differ;
  - quotient negated if signs of A and B differ;
  - remainder takes the sign of A.
  - At E33: hi/lo written, state IDLE, done=1 for exactly the cycle after E33.
  - Start-to-done latency = 34 edges.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product.
  - DIV/DIVU: lo = quotient (truncated toward zero), hi = remainder.
- Divide by zero (B=0, any div op): full latency, lo=32'hFFFF_FFFF, hi=A unmodified (no sign fix).
- Signed overflow: 32'h8000_0000 / 32'hFFFF_FFFF gives lo=32'h8000_0000, hi=0.
- MTHI/MTLO (IDLE, start=1):
  - hi or lo = A at that edge;
  - busy stays 0, done stays 0.
- Undefined op with start=1: no effect.
- start while busy: ignored, no queuing. The hazard unit guarantees a stall; the bench checks the ignore.
- cancel while busy: next edge returns to IDLE; hi/lo unchanged; no done.
- cancel with start on the same edge in IDLE: start is ignored.
- cancel in FIX: wins; no write, no done.
- hi/lo hold their value except on the writes listed above.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package muldiv_pkg: op encodings (OP_MULT..OP_MTLO), state encodings (S_IDLE, S_CALC, S_FIX), WIDTH default.
- One natural sub-module: muldiv_datapath, holding the shift-add/restoring step logic and sign fix. The FSM, counter and hi/lo registers stay in muldiv_unit.

Test Plan:
- MULT A=32'hFFFF_FFFD (-3), B=7 -> after 34 edges hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB, done pulse 1 cycle, busy high 33 cycles.
- MULTU A=B=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001; DIVU A=100, B=7 -> lo=14, hi=2.
- DIV A=32'hFFFF_FFF9 (-7), B=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIV 32'h8000_0000 / 32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
- DIVU A=5, B=0 -> lo=32'hFFFF_FFFF, hi=5 after 34 edges.
- MTHI A=32'h1234_5678, then MTLO A=32'hCAFE_0000 -> hi/lo updated on the next edge, busy=0, done=0.
- MULT 3*4 issued; start with new op at cycle 5 is ignored; cancel at cycle 10 -> busy=0 next cycle, hi/lo keep prior values, no done. Separate run: rst at cycle 20 of a DIV -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the multiply/divide unit: operation encodings,
//   FSM state encodings, default operand width and an op classifier.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } state_e;

   // True for the four ops that run through the iterative datapath.
   function automatic logic is_muldiv(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) ||
             (op == OP_DIV)  || (op == OP_DIVU);
   endfunction

   // Signed variants need magnitude conversion and a final sign fix.
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath
//   Working registers and per-cycle step logic for the iterative unit.
//   Multiply is shift-add (one multiplier bit per step), divide is
//   restoring (one quotient bit per step); both share one 2*WIDTH
//   accumulator. The sign-fixed result is presented combinationally.
// Ports:
//   clk     rising-edge clock
//   load    capture operands (magnitudes), signs and op kind
//   step    perform one iteration
//   op      operation code at load time
//   a, b    raw operands
//   res_hi  fixed HI result (remainder or product upper half)
//   res_lo  fixed LO result (quotient or product lower half)
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
)
(
   input  logic             clk,
   input  logic             load,
   input  logic             step,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   // Multiply: accumulator low half starts as the multiplier and is
   // shifted out LSB first while partial sums enter from the top.
   function automatic logic [2*WIDTH-1:0] mul_step(
      input logic [2*WIDTH-1:0] acc,
      input logic [WIDTH-1:0]   mcand
   );
      logic [WIDTH:0] sum;
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
            (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      return {sum, acc[WIDTH-1:1]};
   endfunction

   // Restoring divide: upper half is the running remainder, lower half
   // shifts dividend bits out and quotient bits in. The trial remainder
   // needs WIDTH+1 bits since it can reach twice the divisor.
   function automatic logic [2*WIDTH-1:0] div_step(
      input logic [2*WIDTH-1:0] acc,
      input logic [WIDTH-1:0]   dvsr
   );
      logic [WIDTH:0]   r;
      logic [WIDTH+1:0] diff;
      r    = acc[2*WIDTH-1:WIDTH-1];
      diff = {1'b0, r} - {2'b00, dvsr};
      if (!diff[WIDTH+1])
         return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         return {r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   endfunction

   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   a_raw_q;
   logic               is_div_q;
   logic               neg_res_q;
   logic               neg_rem_q;
   logic               bzero_q;

   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic                    a_neg;
   logic                    b_neg;
   logic [WIDTH-1:0]        a_mag;
   logic [WIDTH-1:0]        b_mag;

   always_comb begin
      a_s   = $signed(a);
      b_s   = $signed(b);
      a_neg = is_signed_op(op) && (a_s < 0);
      b_neg = is_signed_op(op) && (b_s < 0);
      // -(-2^(W-1)) wraps to itself, which is the correct unsigned magnitude.
      a_mag = a_neg ? WIDTH'(-a_s) : a;
      b_mag = b_neg ? WIDTH'(-b_s) : b;
   end

   always_ff @(posedge clk) begin
      if (load) begin
         is_div_q  <= is_div_op(op);
         neg_res_q <= a_neg ^ b_neg;
         neg_rem_q <= a_neg;
         bzero_q   <= (b == '0);
         a_raw_q   <= a;
         if (is_div_op(op)) begin
            acc_q  <= {{WIDTH{1'b0}}, a_mag};
            opnd_q <= b_mag;
         end else begin
            acc_q  <= {{WIDTH{1'b0}}, b_mag};
            opnd_q <= a_mag;
         end
      end else if (step) begin
         acc_q <= is_div_q ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
      end
   end

   // Sign fix. Divide-by-zero bypasses it: raw dividend to HI, all ones to LO.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   always_comb begin
      prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
      quo      = acc_q[WIDTH-1:0];
      rem      = acc_q[2*WIDTH-1:WIDTH];
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      if (is_div_q) begin
         if (bzero_q) begin
            res_hi = a_raw_q;
            res_lo = '1;
         end else begin
            res_hi = neg_rem_q ? (~rem + 1'b1) : rem;
            res_lo = neg_res_q ? (~quo + 1'b1) : quo;
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide unit with HI/LO registers for the EX stage.
//   IDLE -> CALC (WIDTH steps) -> FIX (1 cycle, writes hi/lo) -> IDLE.
//   MTHI/MTLO write hi/lo directly from IDLE without going busy.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   issue request
//   op      operation code (MULT/MULTU/DIV/DIVU/MTHI/MTLO, others no-op)
//   A, B    rs / rt operands
//   cancel  flush; aborts in-flight op and blocks a same-edge issue
//   busy    high while not IDLE
//   done    one-cycle pulse after a MULT/DIV result lands in hi/lo
//   hi, lo  HI/LO registers
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 5
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic             load;
   logic             step;
   logic             wr;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk    (clk),
      .load   (load),
      .step   (step),
      .op     (op),
      .a      (A),
      .b      (B),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      wr      = 1'b0;
      mthi    = 1'b0;
      mtlo    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !cancel) begin
               if (is_muldiv(op)) begin
                  load    = 1'b1;
                  state_d = S_CALC;
               end
               mthi = (op == OP_MTHI);
               mtlo = (op == OP_MTLO);
            end
         end
         S_CALC: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               step = 1'b1;
               if (cnt_q == CNT_LAST)
                  state_d = S_FIX;
            end
         end
         S_FIX: begin
            // A flush arriving in FIX still suppresses the write.
            state_d = S_IDLE;
            wr      = !cancel;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= wr;
         if (load)
            cnt_q <= '0;
         else if (step)
            cnt_q <= cnt_q + CNT_W'(1);
         if (wr) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end else begin
            if (mthi) hi_q <= A;
            if (mtlo) lo_q <= A;
         end
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed and randomized stimulus against a plain-arithmetic model of
//   the MIPS HI/LO multiply/divide semantics.
module tb_muldiv_unit;

   localparam logic [2:0] C_MULT  = 3'd0;
   localparam logic [2:0] C_MULTU = 3'd1;
   localparam logic [2:0] C_DIV   = 3'd2;
   localparam logic [2:0] C_DIVU  = 3'd3;
   localparam logic [2:0] C_MTHI  = 3'd4;
   localparam logic [2:0] C_MTLO  = 3'd5;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          checks;
   int          failures;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .A      (A),
      .B      (B),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Architectural result of one op applied to the expected HI/LO.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         C_MULT:  begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
         C_MULTU: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
         C_DIV, C_DIVU: begin
            if (b == 32'd0) begin
               exp_hi = a;
               exp_lo = 32'hFFFF_FFFF;
            end else if (o == C_DIV) begin
               exp_lo = 32'(sa / sb);
               exp_hi = 32'(sa % sb);
            end else begin
               exp_lo = a / b;
               exp_hi = a % b;
            end
         end
         C_MTHI:  exp_hi = a;
         C_MTLO:  exp_lo = a;
         default: ;
      endcase
   endfunction

   // Issue a MULT/DIV op, optionally poke a second start at cycle poke_cyc.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int poke_cyc);
      int busy_n;
      int lat;
      bit ovl;
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(negedge clk);
      start = 1'b0;
      busy_n = 0; lat = 0; ovl = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         if (busy) busy_n++;
         if (busy && done) ovl = 1'b1;
         if (done) begin
            lat = c;
            break;
         end
         start = (c == poke_cyc);
         if (c == poke_cyc) begin
            op = C_DIV; A = 32'h0000_0064; B = 32'h0000_0003;
         end
         @(negedge clk);
      end
      start = 1'b0;
      model(o, a, b);
      chk("latency", 64'(lat), 64'd34);
      chk("busy_cycles", 64'(busy_n), 64'd33);
      chk("busy_done_overlap", {63'd0, ovl}, 64'd0);
      chk("hi", {32'd0, hi}, {32'd0, exp_hi});
      chk("lo", {32'd0, lo}, {32'd0, exp_lo});
      @(negedge clk);
      chk("done_width", {63'd0, done}, 64'd0);
   endtask

   // One-edge ops: MTHI/MTLO/undefined, optionally with cancel asserted.
   task automatic run_simple(input logic [2:0] o, input logic [31:0] a, input logic cxl);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = $urandom; cancel = cxl;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      if (!cxl) model(o, a, 32'd0);
      chk("simple_busy", {63'd0, busy}, 64'd0);
      chk("simple_done", {63'd0, done}, 64'd0);
      chk("simple_hi", {32'd0, hi}, {32'd0, exp_hi});
      chk("simple_lo", {32'd0, lo}, {32'd0, exp_lo});
   endtask

   // Issue an op, poke start at cycle 5, flush it during cycle cyc.
   task automatic run_cancel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input int cyc);
      int done_n;
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(negedge clk);
      for (int c = 1; c < cyc; c++) begin
         start = (c == 5);
         if (c == 5) begin
            op = C_DIVU; A = 32'd9; B = 32'd2;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("cancel_pre_busy", {63'd0, busy}, 64'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", {63'd0, busy}, 64'd0);
      done_n = 0;
      for (int c = 0; c < 40; c++) begin
         if (done || busy) done_n++;
         @(negedge clk);
      end
      chk("cancel_no_done", 64'(done_n), 64'd0);
      chk("cancel_hi", {32'd0, hi}, {32'd0, exp_hi});
      chk("cancel_lo", {32'd0, lo}, {32'd0, exp_lo});
   endtask

   initial begin
      checks = 0; failures = 0;
      exp_hi = '0; exp_lo = '0;
      rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; A = '0; B = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);

      run_op(C_MULT,  32'hFFFF_FFFD, 32'd7, 0);
      chk("mult_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
      chk("mult_neg_lo", {32'd0, lo}, 64'hFFFF_FFEB);
      run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("multu_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
      chk("multu_max_lo", {32'd0, lo}, 64'h0000_0001);
      run_op(C_DIVU,  32'd100, 32'd7, 0);
      chk("divu_lo", {32'd0, lo}, 64'd14);
      chk("divu_hi", {32'd0, hi}, 64'd2);
      run_op(C_DIV,   32'hFFFF_FFF9, 32'd2, 0);
      chk("div_neg_lo", {32'd0, lo}, 64'hFFFF_FFFD);
      chk("div_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
      run_op(C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
      chk("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
      chk("div_ovf_hi", {32'd0, hi}, 64'd0);
      run_op(C_DIVU,  32'd5, 32'd0, 0);
      chk("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
      chk("div0_hi", {32'd0, hi}, 64'd5);
      run_op(C_DIV,   32'hFFFF_FFF0, 32'd0, 0);

      run_simple(C_MTHI, 32'h1234_5678, 1'b0);
      run_simple(C_MTLO, 32'hCAFE_0000, 1'b0);
      chk("mthi_val", {32'd0, hi}, 64'h1234_5678);
      chk("mtlo_val", {32'd0, lo}, 64'hCAFE_0000);
      run_simple(3'd6, 32'hDEAD_BEEF, 1'b0);
      run_simple(C_MTHI, 32'h0BAD_F00D, 1'b1);

      // start while busy is ignored: result and timing stay those of MULTU
      run_op(C_MULTU, 32'h0001_0003, 32'h0000_0101, 5);

      run_cancel(C_MULT, 32'd3, 32'd4, 10);
      run_cancel(C_DIV,  32'hFFFF_FF00, 32'd7, 33);

      // start and cancel together in IDLE
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = C_MULT; A = 32'd6; B = 32'd7;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("idle_cancel_busy", {63'd0, busy}, 64'd0);

      for (int i = 0; i < 16; i++) begin
         logic [2:0]  ro;
         logic [31:0] ra;
         logic [31:0] rb;
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         if (i == 3) begin ro = C_DIV; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         if (ro <= C_DIVU) run_op(ro, ra, rb, 0);
         else run_simple(ro, ra, 1'b0);
      end

      // reset in the middle of a divide
      @(negedge clk);
      start = 1'b1; op = C_DIV; A = 32'd1000; B = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_hi = '0; exp_lo = '0;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      chk("midrst_hi", {32'd0, hi}, 64'd0);
      chk("midrst_lo", {32'd0, lo}, 64'd0);
      run_op(C_DIVU, 32'd100, 32'd7, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
